// File: rtl/id_instr_assembler.sv
// IF/ID buffer: joins an opcode word and its trailing 16-bit immediate word into one decode packet.
// Latency: 1 cycle from the last word of an instruction to out_valid; a two-word instruction emits nothing after its first word.
// Backpressure: stall freezes all state and outputs and ignores fetch; flush overrides stall and emits a bubble.
// Build option: define ID_IMM_SEXT_EN to sign-extend the immediate (default build zero-extends it).
module id_instr_assembler #(
    parameter int                         OPC_MSB       = 15,
    parameter int                         OPC_LSB       = 11,
    parameter logic [OPC_MSB-OPC_LSB:0]   IMM_OPC_MASK  = 5'b11000,
    parameter logic [OPC_MSB-OPC_LSB:0]   IMM_OPC_MATCH = 5'b11000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [31:0] out_imm,
    output logic        out_has_imm,
    output logic [31:0] out_pc,
    output logic        imm_pending
);

    typedef enum logic {
        S_FIRST = 1'b0,
        S_IMM   = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] hold_instr;
    logic [31:0] hold_pc;
    logic        needs_imm;
    logic [31:0] imm_ext;

    // Opcode classification of the incoming word; only meaningful when the FSM expects a first word.
    always_comb begin
        needs_imm = ((in_instr[OPC_MSB:OPC_LSB] & IMM_OPC_MASK) == IMM_OPC_MATCH);
    end

    // Widen the immediate word to 32 bits for decode.
    always_comb begin
`ifdef ID_IMM_SEXT_EN
        imm_ext = {{16{in_instr[15]}}, in_instr};
`else
        imm_ext = {16'b0, in_instr};
`endif
    end

    // Decode must not redirect a branch while half of an instruction is buffered here.
    assign imm_pending = (state == S_IMM);

    // Assembly FSM with registered decode outputs; priority is reset, flush, stall, then normal flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FIRST;
            hold_instr  <= '0;
            hold_pc     <= '0;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_imm     <= '0;
            out_has_imm <= 1'b0;
            out_pc      <= '0;
        end else if (flush) begin
            // Any partial pair is dropped along with the word presented this cycle.
            state       <= S_FIRST;
            hold_instr  <= '0;
            hold_pc     <= '0;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_imm     <= '0;
            out_has_imm <= 1'b0;
            out_pc      <= '0;
        end else if (!stall) begin
            case (state)
                S_FIRST: begin
                    if (in_valid && needs_imm) begin
                        // Park the opcode word until its immediate arrives.
                        hold_instr <= in_instr;
                        hold_pc    <= in_pc;
                        out_valid  <= 1'b0;
                        state      <= S_IMM;
                    end else if (in_valid) begin
                        out_valid   <= 1'b1;
                        out_instr   <= in_instr;
                        out_imm     <= '0;
                        out_has_imm <= 1'b0;
                        out_pc      <= in_pc;
                    end else begin
                        out_valid   <= 1'b0;
                        out_instr   <= '0;
                        out_imm     <= '0;
                        out_has_imm <= 1'b0;
                        out_pc      <= '0;
                    end
                end
                S_IMM: begin
                    if (in_valid) begin
                        // Second word is pure data; it is never examined as an opcode.
                        out_valid   <= 1'b1;
                        out_instr   <= hold_instr;
                        out_imm     <= imm_ext;
                        out_has_imm <= 1'b1;
                        out_pc      <= hold_pc;
                        state       <= S_FIRST;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_FIRST;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_instr_assembler.sv
// Directed bench for id_instr_assembler with a per-cycle expectation scoreboard.
// Driver pushes the expected post-edge outputs for every cycle it drives; monitor pops and compares.
// Expected values are hand-computed; the immediate extension follows ID_IMM_SEXT_EN.
module tb_id_instr_assembler;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [31:0] in_pc;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [31:0] out_imm;
    logic        out_has_imm;
    logic [31:0] out_pc;
    logic        imm_pending;

    typedef struct packed {
        logic        v;
        logic        p;
        logic        chk;
        logic [15:0] instr;
        logic [31:0] imm;
        logic        h;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_no = 0;

`ifdef ID_IMM_SEXT_EN
    localparam logic [31:0] IMM_8001 = 32'hFFFF8001;
`else
    localparam logic [31:0] IMM_8001 = 32'h00008001;
`endif

    id_instr_assembler dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .stall       (stall),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_imm     (out_imm),
        .out_has_imm (out_has_imm),
        .out_pc      (out_pc),
        .imm_pending (imm_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and record what the outputs must look like after the next edge.
    // ck=0 means data fields are don't-care (only valid and imm_pending are checked).
    task automatic cyc(input logic r, input logic fl, input logic st, input logic iv,
                       input logic [15:0] w, input logic [31:0] pc,
                       input logic ev, input logic ep, input logic ck,
                       input logic [15:0] ei, input logic [31:0] em,
                       input logic eh, input logic [31:0] epc);
        exp_t e;
        @(negedge clk);
        rst      = r;
        flush    = fl;
        stall    = st;
        in_valid = iv;
        in_instr = w;
        in_pc    = pc;
        e.v = ev; e.p = ep; e.chk = ck; e.instr = ei; e.imm = em; e.h = eh; e.pc = epc;
        sb.push_back(e);
    endtask

    // Monitor: after every edge, compare presented outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cyc_no++;
                total++;
                if (out_valid !== e.v || imm_pending !== e.p ||
                    (e.chk && (out_instr !== e.instr || out_imm !== e.imm ||
                               out_has_imm !== e.h || out_pc !== e.pc))) begin
                    bad++;
                    $display("FAIL cycle%0d: got v=%b p=%b instr=%h imm=%h h=%b pc=%h ; want v=%b p=%b instr=%h imm=%h h=%b pc=%h (data checked=%b)",
                             cyc_no, out_valid, imm_pending, out_instr, out_imm, out_has_imm, out_pc,
                             e.v, e.p, e.instr, e.imm, e.h, e.pc, e.chk);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        in_instr = 16'h0; in_pc = 32'h0;

        // Reset for two cycles: everything zero.
        cyc(1,0,0,0,16'h0000,32'h00, 0,0,1,16'h0000,32'h0,0,32'h00);
        cyc(1,0,0,0,16'h0000,32'h00, 0,0,1,16'h0000,32'h0,0,32'h00);

        // Single-word instruction, 1-cycle latency.
        cyc(0,0,0,1,16'h2345,32'h20, 1,0,1,16'h2345,32'h0,0,32'h20);

        // Two-word instruction C100 + 8001.
        cyc(0,0,0,1,16'hC100,32'h21, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,0,0,1,16'h8001,32'h22, 1,0,1,16'hC100,IMM_8001,1,32'h21);

        // Gap of three idle cycles between opcode and immediate.
        cyc(0,0,0,1,16'hC100,32'h30, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,0,0,0,16'h0000,32'h31, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,0,0,0,16'h0000,32'h32, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,0,0,0,16'h0000,32'h33, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,0,0,1,16'h0005,32'h34, 1,0,1,16'hC100,32'h5,1,32'h30);

        // Idle cycle in S_FIRST: full bubble.
        cyc(0,0,0,0,16'h0000,32'h35, 0,0,1,16'h0000,32'h0,0,32'h00);

        // NOP word is passed through as a valid packet.
        cyc(0,0,0,1,16'h0000,32'h40, 1,0,1,16'h0000,32'h0,0,32'h40);

        // Stall in S_IMM with garbage input keeps the held word.
        cyc(0,0,0,1,16'hF800,32'h50, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,0,1,1,16'hFFFF,32'hEE, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,0,1,1,16'hDEAD,32'hEF, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,0,0,1,16'h0007,32'h52, 1,0,1,16'hF800,32'h7,1,32'h50);

        // Stall while a packet is presented: outputs frozen.
        cyc(0,0,1,1,16'h1111,32'h60, 1,0,1,16'hF800,32'h7,1,32'h50);
        cyc(0,0,1,1,16'hC222,32'h61, 1,0,1,16'hF800,32'h7,1,32'h50);
        cyc(0,0,0,0,16'h0000,32'h62, 0,0,1,16'h0000,32'h0,0,32'h00);

        // Flush with stall in S_IMM: bubble, pair dropped, next word decodes fresh.
        cyc(0,0,0,1,16'hC100,32'h70, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,1,1,1,16'h9999,32'h71, 0,0,1,16'h0000,32'h0,0,32'h00);
        cyc(0,0,0,1,16'h1234,32'h72, 1,0,1,16'h1234,32'h0,0,32'h72);

        // Flush in S_FIRST drops the valid word presented with it.
        cyc(0,1,0,1,16'h2222,32'h80, 0,0,1,16'h0000,32'h0,0,32'h00);

        // Reset asserted mid-pair: partial instruction dropped.
        cyc(0,0,0,1,16'hC100,32'h90, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(1,0,0,1,16'h0005,32'h91, 0,0,1,16'h0000,32'h0,0,32'h00);
        cyc(1,0,1,1,16'h0006,32'h91, 0,0,1,16'h0000,32'h0,0,32'h00);
        cyc(0,0,0,1,16'h0009,32'h92, 1,0,1,16'h0009,32'h0,0,32'h92);

        // Positive immediate boundary: 7FFF is identical in both builds.
        cyc(0,0,0,1,16'hC000,32'hA0, 0,1,0,16'h0000,32'h0,0,32'h00);
        cyc(0,0,0,1,16'h7FFF,32'hA1, 1,0,1,16'hC000,32'h00007FFF,1,32'hA0);

        // Opcode just outside the match (10111): single word.
        cyc(0,0,0,1,16'hBFFF,32'hB0, 1,0,1,16'hBFFF,32'h0,0,32'hB0);

        cyc(0,0,0,0,16'h0000,32'h00, 0,0,1,16'h0000,32'h0,0,32'h00);

        // Let the monitor drain the last expectation, then confirm nothing went unchecked.
        @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
